// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> UPDATE, with HALT/resume and fetch-timeout FAULT.
// Optional statistics counters are compiled in when PCSEQ_STATS_EN is defined.
`ifndef PC_OP_LEN
`define PC_OP_LEN        3
`define PC_OP_NEXT_STEP  3'd0
`define PC_OP_IMM_JMP    3'd1
`define PC_OP_REG_JMP    3'd2
`define PC_OP_OFFSET_JMP 3'd3
`define PC_OP_HALT       3'd4
`endif

module pc_sequencer #(
   parameter int FETCH_TIMEOUT = 16
`ifdef PCSEQ_STATS_EN
   ,
   parameter int CNT_W         = 32
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req,
   input  logic                   imem_ack,
   input  logic [31:0]            instr,
   output logic [31:0]            ir,
   input  logic                   is_j,
   input  logic                   is_jr,
   input  logic                   is_branch,
   input  logic                   is_halt,
   output logic                   ex_start,
   input  logic                   ex_done,
   input  logic                   br_taken,
   input  logic                   resume,
   output logic [`PC_OP_LEN-1:0]  pc_op,
   output logic                   halted,
   output logic                   fault,
`ifdef PCSEQ_STATS_EN
   output logic [CNT_W-1:0]       cyc_cnt,
   output logic [CNT_W-1:0]       instr_cnt,
   output logic [CNT_W-1:0]       taken_cnt,
`endif
   output logic [2:0]             dbg_state
);

   // Handshakes: imem_req is a level held until imem_ack is seen in FETCH;
   // ex_start pulses once, then ex_done is accepted in any EXEC cycle.
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_EXEC   = 3'd1,
      S_UPDATE = 3'd2,
      S_HALT   = 3'd3,
      S_FAULT  = 3'd4
   } state_e;

   localparam int               TO_W    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
   localparam bit               TO_EN   = (FETCH_TIMEOUT != 0);

   state_e                 state_q, state_d;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic [31:0]            ir_q, ir_d;
   logic                   ex_start_q, ex_start_d;
   logic                   taken_q, taken_d;
   logic                   force_next_q, force_next_d;
   logic [`PC_OP_LEN-1:0]  pc_op_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_FETCH;
         to_cnt_q     <= '0;
         ir_q         <= '0;
         ex_start_q   <= 1'b0;
         taken_q      <= 1'b0;
         force_next_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         to_cnt_q     <= to_cnt_d;
         ir_q         <= ir_d;
         ex_start_q   <= ex_start_d;
         taken_q      <= taken_d;
         force_next_q <= force_next_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      to_cnt_d     = '0;
      ir_d         = ir_q;
      ex_start_d   = 1'b0;
      taken_d      = taken_q;
      force_next_d = 1'b0;
      pc_op_c      = `PC_OP_HALT;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               ir_d       = instr;
               ex_start_d = 1'b1;
               state_d    = S_EXEC;
            end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
               state_d = S_FAULT;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_EXEC: begin
            if (ex_done) begin
               taken_d = br_taken;
               state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            state_d = S_FETCH;
            // A resume from HALT steps past the halt instruction regardless of decode.
            if (force_next_q) begin
               pc_op_c = `PC_OP_NEXT_STEP;
            end else if (is_halt) begin
               pc_op_c = `PC_OP_HALT;
               state_d = S_HALT;
            end else if (is_jr) begin
               pc_op_c = `PC_OP_REG_JMP;
            end else if (is_j) begin
               pc_op_c = `PC_OP_IMM_JMP;
            end else if (is_branch && taken_q) begin
               pc_op_c = `PC_OP_OFFSET_JMP;
            end else begin
               pc_op_c = `PC_OP_NEXT_STEP;
            end
         end
         S_HALT: begin
            if (resume) begin
               force_next_d = 1'b1;
               state_d      = S_UPDATE;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Gated by rst so the request stays low while reset holds the FSM in FETCH.
   assign imem_req  = (state_q == S_FETCH) && rst;
   assign ir        = ir_q;
   assign ex_start  = ex_start_q;
   assign pc_op     = pc_op_c;
   assign halted    = (state_q == S_HALT);
   assign fault     = (state_q == S_FAULT);
   assign dbg_state = state_q;

`ifdef PCSEQ_STATS_EN
   logic [CNT_W-1:0] cyc_cnt_q, instr_cnt_q, taken_cnt_q;
   logic             upd_taken;

   assign upd_taken = (state_q == S_UPDATE) && (pc_op_c != `PC_OP_NEXT_STEP) &&
                      (pc_op_c != `PC_OP_HALT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_cnt_q   <= '0;
         instr_cnt_q <= '0;
         taken_cnt_q <= '0;
      end else begin
         if ((state_q != S_HALT) && (state_q != S_FAULT)) cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
         if (state_q == S_UPDATE) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
         if (upd_taken) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
   end

   assign cyc_cnt   = cyc_cnt_q;
   assign instr_cnt = instr_cnt_q;
   assign taken_cnt = taken_cnt_q;
`endif

endmodule
